// File: rtl/id_ex_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg_if
// Brief    : ID->EX pipeline bus: ID fields, WB bypass source, EX fields, stall.
// Revision : 1.0
// ============================================================================
interface id_ex_reg_if #(
    parameter int DATA_W = 64
);
    logic              enable;
    logic              flush;

    logic [DATA_W-1:0] pc_ID;
    logic [DATA_W-1:0] rdata1_ID;
    logic [DATA_W-1:0] rdata2_ID;
    logic [DATA_W-1:0] imm_ID;
    logic [4:0]        rs1_ID;
    logic [4:0]        rs2_ID;
    logic [4:0]        rd_ID;
    logic              reg_write_ID;
    logic              mem_read_ID;
    logic              mem_write_ID;
    logic              mem_2_reg_ID;
    logic              alu_src_ID;
    logic              branch_ID;
    logic              jump_ID;
    logic [1:0]        alu_op_ID;
    logic [3:0]        func_ID;

    logic              reg_write_M_WB;
    logic [4:0]        rd_M_WB;
    logic [DATA_W-1:0] wb_data_M_WB;

    logic [DATA_W-1:0] pc_ID_EX;
    logic [DATA_W-1:0] rdata1_ID_EX;
    logic [DATA_W-1:0] rdata2_ID_EX;
    logic [DATA_W-1:0] imm_ID_EX;
    logic [4:0]        rs1_ID_EX;
    logic [4:0]        rs2_ID_EX;
    logic [4:0]        rd_ID_EX;
    logic              reg_write_ID_EX;
    logic              mem_read_ID_EX;
    logic              mem_write_ID_EX;
    logic              mem_2_reg_ID_EX;
    logic              alu_src_ID_EX;
    logic              branch_ID_EX;
    logic              jump_ID_EX;
    logic [1:0]        alu_op_ID_EX;
    logic [3:0]        func_ID_EX;
    logic              valid_ID_EX;
    logic              load_use_stall;
    logic [15:0]       bubble_count;

    modport master (
        output enable, flush,
        output pc_ID, rdata1_ID, rdata2_ID, imm_ID, rs1_ID, rs2_ID, rd_ID,
        output reg_write_ID, mem_read_ID, mem_write_ID, mem_2_reg_ID,
        output alu_src_ID, branch_ID, jump_ID, alu_op_ID, func_ID,
        output reg_write_M_WB, rd_M_WB, wb_data_M_WB,
        input  pc_ID_EX, rdata1_ID_EX, rdata2_ID_EX, imm_ID_EX,
        input  rs1_ID_EX, rs2_ID_EX, rd_ID_EX,
        input  reg_write_ID_EX, mem_read_ID_EX, mem_write_ID_EX, mem_2_reg_ID_EX,
        input  alu_src_ID_EX, branch_ID_EX, jump_ID_EX, alu_op_ID_EX, func_ID_EX,
        input  valid_ID_EX, load_use_stall, bubble_count
    );

    modport slave (
        input  enable, flush,
        input  pc_ID, rdata1_ID, rdata2_ID, imm_ID, rs1_ID, rs2_ID, rd_ID,
        input  reg_write_ID, mem_read_ID, mem_write_ID, mem_2_reg_ID,
        input  alu_src_ID, branch_ID, jump_ID, alu_op_ID, func_ID,
        input  reg_write_M_WB, rd_M_WB, wb_data_M_WB,
        output pc_ID_EX, rdata1_ID_EX, rdata2_ID_EX, imm_ID_EX,
        output rs1_ID_EX, rs2_ID_EX, rd_ID_EX,
        output reg_write_ID_EX, mem_read_ID_EX, mem_write_ID_EX, mem_2_reg_ID_EX,
        output alu_src_ID_EX, branch_ID_EX, jump_ID_EX, alu_op_ID_EX, func_ID_EX,
        output valid_ID_EX, load_use_stall, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_reg
// Brief    : ID/EX pipeline register with load-use bubble insertion and WB bypass.
// Revision : 1.0
// ============================================================================
module id_ex_reg #(
    parameter int DATA_W = 64
) (
    input  wire               clk,
    input  wire               arst_n,
    id_ex_reg_if.slave        bus
);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_2_reg;
    logic              r_alu_src;
    logic              r_branch;
    logic              r_jump;
    logic [1:0]        r_alu_op;
    logic [3:0]        r_func;
    logic              r_valid;
    logic [15:0]       r_bubble_count;

    logic              w_stall;
    logic              w_bubble;
    logic              w_byp1;
    logic              w_byp2;
    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;

    // A flush overrides the hazard so redirected wrong-path loads never stall.
    assign w_stall  = r_valid && r_mem_read && (r_rd != 5'd0)
                      && ((r_rd == bus.rs1_ID) || (r_rd == bus.rs2_ID))
                      && !bus.flush;
    assign w_bubble = bus.flush || w_stall;

    assign w_byp1   = bus.reg_write_M_WB && (bus.rd_M_WB != 5'd0) && (bus.rd_M_WB == bus.rs1_ID);
    assign w_byp2   = bus.reg_write_M_WB && (bus.rd_M_WB != 5'd0) && (bus.rd_M_WB == bus.rs2_ID);
    assign w_rdata1 = w_byp1 ? bus.wb_data_M_WB : bus.rdata1_ID;
    assign w_rdata2 = w_byp2 ? bus.wb_data_M_WB : bus.rdata2_ID;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_pc           <= '0;
            r_rdata1       <= '0;
            r_rdata2       <= '0;
            r_imm          <= '0;
            r_rs1          <= '0;
            r_rs2          <= '0;
            r_rd           <= '0;
            r_reg_write    <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_2_reg    <= 1'b0;
            r_alu_src      <= 1'b0;
            r_branch       <= 1'b0;
            r_jump         <= 1'b0;
            r_alu_op       <= '0;
            r_func         <= '0;
            r_valid        <= 1'b0;
            r_bubble_count <= '0;
        end else if (bus.enable) begin
            if (w_bubble) begin
                r_pc        <= '0;
                r_rdata1    <= '0;
                r_rdata2    <= '0;
                r_imm       <= '0;
                r_rs1       <= '0;
                r_rs2       <= '0;
                r_rd        <= '0;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_mem_2_reg <= 1'b0;
                r_alu_src   <= 1'b0;
                r_branch    <= 1'b0;
                r_jump      <= 1'b0;
                r_alu_op    <= '0;
                r_func      <= '0;
                r_valid     <= 1'b0;
            end else begin
                r_pc        <= bus.pc_ID;
                r_rdata1    <= w_rdata1;
                r_rdata2    <= w_rdata2;
                r_imm       <= bus.imm_ID;
                r_rs1       <= bus.rs1_ID;
                r_rs2       <= bus.rs2_ID;
                r_rd        <= bus.rd_ID;
                r_reg_write <= bus.reg_write_ID;
                r_mem_read  <= bus.mem_read_ID;
                r_mem_write <= bus.mem_write_ID;
                r_mem_2_reg <= bus.mem_2_reg_ID;
                r_alu_src   <= bus.alu_src_ID;
                r_branch    <= bus.branch_ID;
                r_jump      <= bus.jump_ID;
                r_alu_op    <= bus.alu_op_ID;
                r_func      <= bus.func_ID;
                r_valid     <= 1'b1;
            end
            // Only load-use bubbles are counted; flush bubbles are not.
            if (w_stall && (r_bubble_count != c_CNT_MAX)) begin
                r_bubble_count <= r_bubble_count + 16'd1;
            end
        end
    end

    assign bus.pc_ID_EX        = r_pc;
    assign bus.rdata1_ID_EX    = r_rdata1;
    assign bus.rdata2_ID_EX    = r_rdata2;
    assign bus.imm_ID_EX       = r_imm;
    assign bus.rs1_ID_EX       = r_rs1;
    assign bus.rs2_ID_EX       = r_rs2;
    assign bus.rd_ID_EX        = r_rd;
    assign bus.reg_write_ID_EX = r_reg_write;
    assign bus.mem_read_ID_EX  = r_mem_read;
    assign bus.mem_write_ID_EX = r_mem_write;
    assign bus.mem_2_reg_ID_EX = r_mem_2_reg;
    assign bus.alu_src_ID_EX   = r_alu_src;
    assign bus.branch_ID_EX    = r_branch;
    assign bus.jump_ID_EX      = r_jump;
    assign bus.alu_op_ID_EX    = r_alu_op;
    assign bus.func_ID_EX      = r_func;
    assign bus.valid_ID_EX     = r_valid;
    assign bus.load_use_stall  = w_stall;
    assign bus.bubble_count    = r_bubble_count;
endmodule
`default_nettype wire
